// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage: captures one instruction per valid/ready
// handshake, decodes its fields, steers register numbers from nsel and counts illegal opcodes.
module instr_decode_stage #(
  parameter int         DATA_W     = 16,
  parameter logic [7:0] LEGAL_MASK = 8'b0110_0000,
  parameter int         CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [2:0]        nsel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  logic [15:0]      ir_q, ir_d;
  logic             v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             in_illegal;

  assign in_ready   = !v_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign in_illegal = !LEGAL_MASK[in[15:13]];

  // Flush outranks an accept in the same cycle; the dropped word is never counted.
  always_comb begin
    ir_d  = ir_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (accept) begin
      ir_d = in;
      v_d  = 1'b1;
      if (in_illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (v_q && out_ready) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= '0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      ir_q  <= ir_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid     = v_q;
  assign illegal_count = cnt_q;

  assign opcode  = ir_q[15:13];
  assign op      = ir_q[12:11];
  assign ALUop   = ir_q[12:11];
  assign shift   = ir_q[4:3];
  assign illegal = !LEGAL_MASK[ir_q[15:13]];
  assign sximm8  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

  // Non-one-hot selects read as register 0.
  always_comb begin
    readnum = 3'b000;
    case (nsel)
      3'b100:  readnum = ir_q[10:8];
      3'b010:  readnum = ir_q[7:5];
      3'b001:  readnum = ir_q[2:0];
      default: readnum = 3'b000;
    endcase
  end

  assign writenum = readnum;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: three instances (default, 32-bit datapath,
// 2-bit counter) share stimulus and are compared against a behavioural model.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, out_ready;
  logic [15:0] in_w;
  logic [2:0]  nsel;

  logic        d_in_ready, d_out_valid, d_illegal;
  logic [2:0]  d_opcode, d_readnum, d_writenum;
  logic [1:0]  d_op, d_aluop, d_shift;
  logic [15:0] d_sximm8, d_sximm5;
  logic [7:0]  d_count;

  logic        w_in_ready, w_out_valid, w_illegal;
  logic [2:0]  w_opcode, w_readnum, w_writenum;
  logic [1:0]  w_op, w_aluop, w_shift;
  logic [31:0] w_sximm8, w_sximm5;
  logic [7:0]  w_count;

  logic        c_in_ready, c_out_valid, c_illegal;
  logic [2:0]  c_opcode, c_readnum, c_writenum;
  logic [1:0]  c_op, c_aluop, c_shift;
  logic [15:0] c_sximm8, c_sximm5;
  logic [1:0]  c_count;

  instr_decode_stage u_dut (
    .clk(clk), .reset(reset), .in(in_w), .in_valid(in_valid), .in_ready(d_in_ready),
    .flush(flush), .nsel(nsel), .out_valid(d_out_valid), .out_ready(out_ready),
    .opcode(d_opcode), .op(d_op), .ALUop(d_aluop), .shift(d_shift),
    .readnum(d_readnum), .writenum(d_writenum), .sximm8(d_sximm8), .sximm5(d_sximm5),
    .illegal(d_illegal), .illegal_count(d_count)
  );

  instr_decode_stage #(.DATA_W(32)) u_wide (
    .clk(clk), .reset(reset), .in(in_w), .in_valid(in_valid), .in_ready(w_in_ready),
    .flush(flush), .nsel(nsel), .out_valid(w_out_valid), .out_ready(out_ready),
    .opcode(w_opcode), .op(w_op), .ALUop(w_aluop), .shift(w_shift),
    .readnum(w_readnum), .writenum(w_writenum), .sximm8(w_sximm8), .sximm5(w_sximm5),
    .illegal(w_illegal), .illegal_count(w_count)
  );

  instr_decode_stage #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset(reset), .in(in_w), .in_valid(in_valid), .in_ready(c_in_ready),
    .flush(flush), .nsel(nsel), .out_valid(c_out_valid), .out_ready(out_ready),
    .opcode(c_opcode), .op(c_op), .ALUop(c_aluop), .shift(c_shift),
    .readnum(c_readnum), .writenum(c_writenum), .sximm8(c_sximm8), .sximm5(c_sximm5),
    .illegal(c_illegal), .illegal_count(c_count)
  );

  logic [41:0] d_fields, c_fields;
  logic [73:0] w_fields;
  assign d_fields = {d_opcode, d_op, d_aluop, d_shift, d_sximm8, d_sximm5, d_illegal};
  assign c_fields = {c_opcode, c_op, c_aluop, c_shift, c_sximm8, c_sximm5, c_illegal};
  assign w_fields = {w_opcode, w_op, w_aluop, w_shift, w_sximm8, w_sximm5, w_illegal};

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the stage.
  logic [15:0] m_word = '0;
  bit          m_v    = 1'b0;
  int          m_cnt8 = 0;
  int          m_cnt2 = 0;

  function automatic bit is_illegal(input logic [2:0] opc);
    return !(opc == 3'd5 || opc == 3'd6);
  endfunction

  function automatic logic [31:0] sx8(input logic [15:0] w);
    int v;
    v = int'(w[7:0]);
    if (v >= 128) v = v - 256;
    return 32'(v);
  endfunction

  function automatic logic [31:0] sx5(input logic [15:0] w);
    int v;
    v = int'(w[4:0]);
    if (v >= 16) v = v - 32;
    return 32'(v);
  endfunction

  function automatic logic [41:0] exp_fields(input logic [15:0] w);
    logic [31:0] a, b;
    a = sx8(w);
    b = sx5(w);
    return {w[15:13], w[12:11], w[12:11], w[4:3], a[15:0], b[15:0], is_illegal(w[15:13])};
  endfunction

  function automatic logic [73:0] exp_wide(input logic [15:0] w);
    return {w[15:13], w[12:11], w[12:11], w[4:3], sx8(w), sx5(w), is_illegal(w[15:13])};
  endfunction

  function automatic logic [2:0] exp_rn(input logic [15:0] w, input logic [2:0] s);
    if (s == 3'b100) return w[10:8];
    if (s == 3'b010) return w[7:5];
    if (s == 3'b001) return w[2:0];
    return 3'b000;
  endfunction

  task automatic drive(input bit r, input bit f, input bit iv, input logic [15:0] w,
                       input bit ordy, input logic [2:0] ns);
    reset = r; flush = f; in_valid = iv; in_w = w; out_ready = ordy; nsel = ns;
    #1;
  endtask

  task automatic cycle();
    bit acc;
    acc = in_valid && (!m_v || out_ready);
    if (reset) begin
      m_word = '0; m_v = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (flush) begin
      m_v = 1'b0;
    end else if (acc) begin
      m_word = in_w;
      m_v    = 1'b1;
      if (is_illegal(in_w[15:13])) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end else if (m_v && out_ready) begin
      m_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 16'hFFFF, 0, 3'b100);
    cycle();
    cycle();
    drive(0, 0, 0, 16'h0000, 0, 3'b100);
    cycle();
    n_checks++;
    if ({d_out_valid, d_in_ready, d_count} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got valid/ready/count=%b/%b/%0d, want 0/1/0",
               d_out_valid, d_in_ready, d_count);
    end
    n_checks++;
    if ({d_fields, d_readnum, d_writenum} !== {41'd0, 1'b1, 3'd0, 3'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_fields: got %h rn=%0d wn=%0d, want all zero with illegal=1",
               d_fields, d_readnum, d_writenum);
    end
  endtask

  task automatic test_decode_select();
    logic [2:0] sels [4];
    logic [2:0] want [4];
    sels = '{3'b100, 3'b010, 3'b001, 3'b000};
    want = '{3'd1, 3'd5, 3'd2, 3'd0};
    drive(0, 0, 1, 16'hD1BA, 0, 3'b100);
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if ({d_out_valid, d_opcode, d_op, d_aluop, d_shift, d_sximm8, d_sximm5}
        !== {1'b1, 3'd6, 2'd2, 2'd2, 2'd3, 16'hFFBA, 16'hFFFA}) begin
      n_fail++;
      $display("[TB] FAIL decode_D1BA: got v=%b opc=%0d op=%0d alu=%0d sh=%0d s8=%h s5=%h, want 1 6 2 2 3 ffba fffa",
               d_out_valid, d_opcode, d_op, d_aluop, d_shift, d_sximm8, d_sximm5);
    end
    for (int i = 0; i < 4; i++) begin
      nsel = sels[i];
      #1;
      n_checks++;
      if ({d_readnum, d_writenum} !== {want[i], want[i]}) begin
        n_fail++;
        $display("[TB] FAIL nsel_%b: got rn=%0d wn=%0d, want %0d", sels[i], d_readnum, d_writenum, want[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 16'($urandom), 0, 3'b010);
      n_checks++;
      if (d_in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hold_ready_%0d: got in_ready=%b, want 0", i, d_in_ready);
      end
      cycle();
      n_checks++;
      if ({d_out_valid, d_fields, d_readnum} !== {1'b1, exp_fields(16'hD1BA), 3'd5}) begin
        n_fail++;
        $display("[TB] FAIL hold_fields_%0d: got v=%b %h rn=%0d, want 1 %h 5",
                 i, d_out_valid, d_fields, d_readnum, exp_fields(16'hD1BA));
      end
    end
  endtask

  task automatic test_wide_datapath();
    drive(0, 0, 1, 16'hA07F, 1, 3'b100);
    cycle();
    n_checks++;
    if (w_sximm8 !== 32'h0000007F || w_fields !== exp_wide(16'hA07F)) begin
      n_fail++;
      $display("[TB] FAIL wide_sximm8: got s8=%h fields=%h, want 0000007f %h", w_sximm8, w_fields, exp_wide(16'hA07F));
    end
    drive(0, 0, 1, 16'hA010, 1, 3'b100);
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (w_sximm5 !== 32'hFFFFFFF0 || w_sximm8 !== 32'h00000010) begin
      n_fail++;
      $display("[TB] FAIL wide_sximm5: got s5=%h s8=%h, want fffffff0 00000010", w_sximm5, w_sximm8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4];
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, words[i], 1, 3'b001);
      cycle();
      n_checks++;
      if ({d_out_valid, d_fields, d_readnum} !== {1'b1, exp_fields(words[i]), words[i][2:0]}) begin
        n_fail++;
        $display("[TB] FAIL stream_%0d: got v=%b %h rn=%0d, want 1 %h %0d",
                 i, d_out_valid, d_fields, d_readnum, exp_fields(words[i]), words[i][2:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 16'($urandom), 0, 3'b001);
      n_checks++;
      if (d_in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_ready_%0d: got in_ready=%b, want 0", i, d_in_ready);
      end
      cycle();
      n_checks++;
      if ({d_out_valid, d_fields} !== {1'b1, exp_fields(words[3])}) begin
        n_fail++;
        $display("[TB] FAIL stall_hold_%0d: got v=%b %h, want 1 %h", i, d_out_valid, d_fields, exp_fields(words[3]));
      end
    end
  endtask

  task automatic test_flush();
    logic [15:0] held;
    logic [7:0]  cnt_before;
    held = m_word;
    cnt_before = d_count;
    drive(0, 1, 1, {3'b000, 13'($urandom)}, 1, 3'b100);
    n_checks++;
    if (d_in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_ready: got in_ready=%b, want 1", d_in_ready);
    end
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({d_out_valid, d_count, d_fields} !== {1'b0, cnt_before, exp_fields(held)}) begin
      n_fail++;
      $display("[TB] FAIL flush_drop: got v=%b cnt=%0d %h, want 0 %0d %h",
               d_out_valid, d_count, d_fields, cnt_before, exp_fields(held));
    end
    drive(0, 0, 1, {3'b111, 13'($urandom)}, 0, 3'b100);
    cycle();
    drive(1, 0, 1, 16'($urandom), 1, 3'b100);
    cycle();
    drive(0, 0, 0, 16'h0000, 0, 3'b100);
    n_checks++;
    if ({d_out_valid, d_count, c_count, d_fields} !== {1'b0, 8'd0, 2'd0, exp_fields(16'h0000)}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got v=%b cnt=%0d cnt2=%0d %h, want 0 0 0 %h",
               d_out_valid, d_count, c_count, d_fields, exp_fields(16'h0000));
    end
  endtask

  task automatic test_illegal_count();
    logic [2:0] opcs [6];
    logic [1:0] want2 [6];
    logic       want_ill [6];
    opcs     = '{3'b000, 3'b101, 3'b111, 3'b011, 3'b001, 3'b100};
    want2    = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    want_ill = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(1, 0, 0, 16'h0000, 0, 3'b100);
    cycle();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, {opcs[i], 13'($urandom)}, 1, 3'b100);
      cycle();
      n_checks++;
      if ({c_count, c_illegal, d_count} !== {want2[i], want_ill[i], 8'(m_cnt8)}) begin
        n_fail++;
        $display("[TB] FAIL illegal_%0d: got cnt2=%0d ill=%b cnt8=%0d, want %0d %b %0d",
                 i, c_count, c_illegal, d_count, want2[i], want_ill[i], m_cnt8);
      end
    end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 16'h0000, 0, 3'b100);
    cycle();
    for (int i = 0; i < 260; i++) begin
      drive(0, 0, 1, {3'b111, 13'($urandom)}, 1, 3'b100);
      cycle();
    end
    in_valid = 1'b0;
    n_checks++;
    if ({d_count, c_count} !== {8'hFF, 2'd3}) begin
      n_fail++;
      $display("[TB] FAIL saturate: got cnt8=%0d cnt2=%0d, want 255 3", d_count, c_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
            16'($urandom), ($urandom_range(0, 4) < 3), 3'($urandom));
      n_checks++;
      if ({d_in_ready, w_in_ready, c_in_ready} !== {3{!m_v || out_ready}}) begin
        n_fail++;
        $display("[TB] FAIL rand_ready_%0d: got %b%b%b, want %b", i, d_in_ready, w_in_ready, c_in_ready, !m_v || out_ready);
      end
      cycle();
      n_checks++;
      if ({d_out_valid, d_count, d_fields, d_readnum, d_writenum} !==
          {m_v, 8'(m_cnt8), exp_fields(m_word), exp_rn(m_word, nsel), exp_rn(m_word, nsel)}) begin
        n_fail++;
        $display("[TB] FAIL rand_default_%0d: got v=%b cnt=%0d %h rn=%0d wn=%0d, want %b %0d %h %0d",
                 i, d_out_valid, d_count, d_fields, d_readnum, d_writenum, m_v, m_cnt8,
                 exp_fields(m_word), exp_rn(m_word, nsel));
      end
      n_checks++;
      if ({w_out_valid, w_count, w_fields, w_readnum, w_writenum, c_out_valid, c_count, c_fields,
           c_readnum, c_writenum} !==
          {m_v, 8'(m_cnt8), exp_wide(m_word), exp_rn(m_word, nsel), exp_rn(m_word, nsel), m_v,
           2'(m_cnt2), exp_fields(m_word), exp_rn(m_word, nsel), exp_rn(m_word, nsel)}) begin
        n_fail++;
        $display("[TB] FAIL rand_variants_%0d: wide v=%b cnt=%0d %h, cnt2 v=%b cnt=%0d, want v=%b %0d %h %0d",
                 i, w_out_valid, w_count, w_fields, c_out_valid, c_count, m_v, m_cnt8,
                 exp_wide(m_word), m_cnt2);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_w = '0; out_ready = 1'b0; nsel = 3'b100;
    test_reset();
    test_decode_select();
    test_wide_datapath();
    test_back_to_back();
    test_flush();
    test_illegal_count();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
